// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: sequences a hasher over successive nonces until digest < target or the nonce space ends.
// Optional NONCE_SEARCH_HASH_COUNT_EN adds a saturating hash_count output.
module nonce_search_ctrl #(
    parameter int HDR_BITS = 408
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [HDR_BITS-1:0]    header,
    input  logic [255:0]           target,
    input  logic [31:0]            nonce_start,
    output logic [HDR_BITS+31:0]   msg_out,
    output logic                   begin_hash,
    input  logic                   hash_done,
    input  logic [255:0]           hash_in,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [31:0]            nonce_out,
    output logic [255:0]           hash_out
`ifdef NONCE_SEARCH_HASH_COUNT_EN
    ,
    output logic [31:0]            hash_count
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BEGIN, S_WAIT, S_CHECK} state_t;

    state_t                state_q, state_d;
    logic [HDR_BITS-1:0]   header_q, header_d;
    logic [255:0]          target_q, target_d, hash_q, hash_d, hash_out_q, hash_out_d;
    logic [31:0]           nonce_q, nonce_d, nonce_out_q, nonce_out_d;
    logic [HDR_BITS+31:0]  msg_q, msg_d;
    logic                  found_q, found_d, exh_q, exh_d;
    logic                  accept, hit, last;
`ifdef NONCE_SEARCH_HASH_COUNT_EN
    logic [31:0]           cnt_q, cnt_d;
`endif

    assign accept = state_q == S_IDLE && start && !abort;
    assign hit    = hash_q < target_q;
    assign last   = nonce_q == 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // abort overrides every transition out of a busy state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = accept ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_BEGIN;
            S_BEGIN: state_d = S_WAIT;
            S_WAIT:  state_d = hash_done ? S_CHECK : S_WAIT;
            S_CHECK: state_d = (hit || last) ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        busy       = state_q != S_IDLE;
        begin_hash = state_q == S_BEGIN && !abort;
    end

    always_comb begin
        header_d    = header_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        msg_d       = msg_q;
        hash_d      = hash_q;
        found_d     = found_q;
        exh_d       = exh_q;
        nonce_out_d = nonce_out_q;
        hash_out_d  = hash_out_q;
        if (accept) begin
            header_d = header;
            target_d = target;
            nonce_d  = nonce_start;
            found_d  = 1'b0;
            exh_d    = 1'b0;
        end
        if (state_q == S_LOAD && !abort) msg_d = {header_q, nonce_q};
        if (state_q == S_WAIT && hash_done && !abort) hash_d = hash_in;
        if (state_q == S_CHECK && !abort) begin
            if (hit) begin
                found_d     = 1'b1;
                nonce_out_d = nonce_q;
                hash_out_d  = hash_q;
            end else if (last) begin
                exh_d = 1'b1;
            end else begin
                nonce_d = nonce_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            header_q    <= '0;
            target_q    <= '0;
            nonce_q     <= '0;
            msg_q       <= '0;
            hash_q      <= '0;
            found_q     <= 1'b0;
            exh_q       <= 1'b0;
            nonce_out_q <= '0;
            hash_out_q  <= '0;
        end else begin
            header_q    <= header_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            msg_q       <= msg_d;
            hash_q      <= hash_d;
            found_q     <= found_d;
            exh_q       <= exh_d;
            nonce_out_q <= nonce_out_d;
            hash_out_q  <= hash_out_d;
        end
    end

    assign msg_out   = msg_q;
    assign found     = found_q;
    assign exhausted = exh_q;
    assign nonce_out = nonce_out_q;
    assign hash_out  = hash_out_q;

`ifdef NONCE_SEARCH_HASH_COUNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = '0;
        else if (state_q == S_WAIT && hash_done && !abort && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign hash_count = cnt_q;
`endif
endmodule
